// File: rtl/store_port_arbiter.sv
// -----------------------------------------------------------------------------
// store_port_arbiter
//
// Shares a single memory write port between N_PORTS store channels. Requests
// are granted round-robin into a one-entry registered write stage. A channel
// stays busy from grant until its completion token has been consumed, and that
// token is only raised once memory has accepted the channel's write, so each
// channel has at most one store in flight and its stores stay ordered.
//
// Ports
//   clock          in   rising-edge clock
//   reset          in   asynchronous, active-low reset
//   st_valid       in   [N_PORTS]         per-channel store request
//   st_address     in   [N_PORTS*ADDR_W]  channel i at [i*ADDR_W +: ADDR_W]
//   st_data        in   [N_PORTS*DATA_W]  channel i at [i*DATA_W +: DATA_W]
//   st_ready       out  [N_PORTS]         grant, one-hot or zero
//   st_done_valid  out  [N_PORTS]         completion token pending
//   st_done_ready  in   [N_PORTS]         completion token consumed
//   mem_wr_valid   out  write held in the output stage
//   mem_wr_addr    out  [ADDR_W]  held write address
//   mem_wr_data    out  [DATA_W]  held write data
//   mem_wr_id      out  [ID_W]    source channel of the held write
//   mem_wr_ready   in   memory accepts the held write this cycle
//   idle           out  no held write and no busy channel
// -----------------------------------------------------------------------------
module store_port_arbiter #(
    parameter int N_PORTS = 5,
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 64,
    localparam int ID_W   = $clog2(N_PORTS)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N_PORTS-1:0]          st_valid,
    input  logic [N_PORTS*ADDR_W-1:0]   st_address,
    input  logic [N_PORTS*DATA_W-1:0]   st_data,
    output logic [N_PORTS-1:0]          st_ready,
    output logic [N_PORTS-1:0]          st_done_valid,
    input  logic [N_PORTS-1:0]          st_done_ready,
    output logic                        mem_wr_valid,
    output logic [ADDR_W-1:0]           mem_wr_addr,
    output logic [DATA_W-1:0]           mem_wr_data,
    output logic [ID_W-1:0]             mem_wr_id,
    input  logic                        mem_wr_ready,
    output logic                        idle
);

    typedef enum logic {S_EMPTY, S_HOLD} state_t;

    state_t              state_q, state_d;
    logic [N_PORTS-1:0]  busy_q, busy_d;
    logic [N_PORTS-1:0]  done_pend_q, done_pend_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [ID_W-1:0]     id_q;

    logic                slot_free;
    logic [N_PORTS-1:0]  eligible;
    logic                gnt_found;
    logic [ID_W-1:0]     gnt_idx;
    logic [N_PORTS-1:0]  gnt_oh;
    logic [N_PORTS-1:0]  acc_oh;
    logic [N_PORTS-1:0]  done_hs;

    assign mem_wr_valid  = (state_q == S_HOLD);
    assign mem_wr_addr   = addr_q;
    assign mem_wr_data   = data_q;
    assign mem_wr_id     = id_q;
    assign st_done_valid = done_pend_q;
    assign idle          = !mem_wr_valid && (busy_q == '0);

    // A new write may load on the same edge the held one is accepted.
    assign slot_free = !mem_wr_valid || mem_wr_ready;
    assign eligible  = st_valid & ~busy_q;

    // Round-robin search starting at rr_ptr. Grants are suppressed while
    // reset is asserted so st_ready reads zero during reset.
    always_comb begin : arb
        int cand;
        cand      = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= N_PORTS) cand = cand - N_PORTS;
            if (!gnt_found && slot_free && reset && eligible[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[ID_W-1:0];
            end
        end
        gnt_oh = '0;
        if (gnt_found) gnt_oh[gnt_idx] = 1'b1;
        st_ready = gnt_oh;
    end

    always_comb begin
        acc_oh = '0;
        if (mem_wr_valid && mem_wr_ready) acc_oh[id_q] = 1'b1;
        // Handshake only counts where a token is actually pending.
        done_hs     = done_pend_q & st_done_ready;
        busy_d      = (busy_q | gnt_oh) & ~done_hs;
        done_pend_d = (done_pend_q | acc_oh) & ~done_hs;
        rr_ptr_d    = rr_ptr_q;
        if (gnt_found) begin
            rr_ptr_d = (gnt_idx == ID_W'(N_PORTS - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    // Output-stage FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (gnt_found) state_d = S_HOLD;
            S_HOLD: begin
                if (mem_wr_ready) state_d = gnt_found ? S_HOLD : S_EMPTY;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_EMPTY;
            busy_q      <= '0;
            done_pend_q <= '0;
            rr_ptr_q    <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            id_q        <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_pend_q <= done_pend_d;
            rr_ptr_q    <= rr_ptr_d;
            if (gnt_found) begin
                addr_q <= st_address[gnt_idx*ADDR_W +: ADDR_W];
                data_q <= st_data[gnt_idx*DATA_W +: DATA_W];
                id_q   <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_store_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_store_port_arbiter
//
// Directed phases plus a randomized phase drive the arbiter. A transaction-level
// reference model (per-channel busy/pending arrays, a round-robin pointer and a
// held-write flag) predicts grants, tokens and idle each cycle and pushes every
// expected memory write into a queue; an independent monitor pops that queue
// and compares whatever the DUT presents on the memory port.
// -----------------------------------------------------------------------------
module tb_store_port_arbiter;
    localparam int N      = 5;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 64;
    localparam int ID_W   = $clog2(N);

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic [N-1:0]        st_valid = '0;
    logic [N*ADDR_W-1:0] st_address = '0;
    logic [N*DATA_W-1:0] st_data = '0;
    logic [N-1:0]        st_ready;
    logic [N-1:0]        st_done_valid;
    logic [N-1:0]        st_done_ready = '0;
    logic                mem_wr_valid;
    logic [ADDR_W-1:0]   mem_wr_addr;
    logic [DATA_W-1:0]   mem_wr_data;
    logic [ID_W-1:0]     mem_wr_id;
    logic                mem_wr_ready = 1'b0;
    logic                idle;

    store_port_arbiter #(.N_PORTS(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset),
        .st_valid(st_valid), .st_address(st_address), .st_data(st_data),
        .st_ready(st_ready), .st_done_valid(st_done_valid), .st_done_ready(st_done_ready),
        .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_id(mem_wr_id), .mem_wr_ready(mem_wr_ready), .idle(idle)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   id;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_busy[N];
    bit m_dpend[N];
    int m_rr;
    bit m_hold;
    int m_hold_id;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_busy[i]  = 0;
            m_dpend[i] = 0;
        end
        m_rr = 0; m_hold = 0; m_hold_id = 0;
        exp_q.delete();
    endtask

    initial model_reset();

    // Evaluates the cycle just before the next rising edge, inputs settled.
    always @(negedge clock) begin
        #1;
        if (!reset) begin
            model_reset();
        end else begin
            logic [N-1:0] e_ready, e_dv;
            bit any_busy, free;
            int g;
            bit hs[N];
            g = -1;
            free = !m_hold || mem_wr_ready;
            if (free) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_rr + k) % N;
                    if (g < 0 && st_valid[c] && !m_busy[c]) g = c;
                end
            end
            e_ready = '0;
            if (g >= 0) e_ready[g] = 1'b1;
            any_busy = 0;
            for (int i = 0; i < N; i++) begin
                e_dv[i] = m_dpend[i];
                if (m_busy[i]) any_busy = 1;
            end
            chk("st_ready", 64'(st_ready), 64'(e_ready));
            chk("st_done_valid", 64'(st_done_valid), 64'(e_dv));
            chk("mem_wr_valid", 64'(mem_wr_valid), 64'(m_hold));
            chk("idle", 64'(idle), 64'(!m_hold && !any_busy));

            // advance model to the state after this edge
            for (int i = 0; i < N; i++) hs[i] = m_dpend[i] && st_done_ready[i];
            if (m_hold && mem_wr_ready) m_dpend[m_hold_id] = 1;
            for (int i = 0; i < N; i++) if (hs[i]) begin
                m_busy[i]  = 0;
                m_dpend[i] = 0;
            end
            if (g >= 0) begin
                wr_t w;
                w.addr = st_address[g*ADDR_W +: ADDR_W];
                w.data = st_data[g*DATA_W +: DATA_W];
                w.id   = ID_W'(g);
                exp_q.push_back(w);
                m_busy[g] = 1;
                m_rr      = (g + 1) % N;
                m_hold    = 1;
                m_hold_id = g;
            end else if (mem_wr_ready) begin
                m_hold = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (reset && mem_wr_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL mem_wr unexpected: got id %0d, expected no write at %0t", mem_wr_id, $time);
            end else begin
                chk("mem_wr_addr", 64'(mem_wr_addr), 64'(exp_q[0].addr));
                chk("mem_wr_data", mem_wr_data, exp_q[0].data);
                chk("mem_wr_id", 64'(mem_wr_id), 64'(exp_q[0].id));
                if (mem_wr_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] dr, input logic mr);
        @(posedge clock);
        #1;
        st_valid      = v;
        st_done_ready = dr;
        mem_wr_ready  = mr;
        for (int i = 0; i < N; i++) begin
            st_address[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
            st_data[i*DATA_W +: DATA_W]    = {$urandom, $urandom};
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " mem_wr_valid"}, 64'(mem_wr_valid), 64'd0);
        chk({tag, " mem_wr_addr"}, 64'(mem_wr_addr), 64'd0);
        chk({tag, " mem_wr_data"}, mem_wr_data, 64'd0);
        chk({tag, " mem_wr_id"}, 64'(mem_wr_id), 64'd0);
        chk({tag, " st_ready"}, 64'(st_ready), 64'd0);
        chk({tag, " st_done_valid"}, 64'(st_done_valid), 64'd0);
        chk({tag, " idle"}, 64'(idle), 64'd1);
    endtask

    initial begin
        #2;
        chk_reset_outputs("reset");
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        // single store on channel 2 held under backpressure for 4 cycles
        step(5'b00100, '0, 1'b0);
        st_address[2*ADDR_W +: ADDR_W] = 2'd3;
        st_data[2*DATA_W +: DATA_W]    = 64'hDEAD;
        repeat (4) step('0, '0, 1'b0);
        step('0, '0, 1'b1);
        repeat (2) step('0, '0, 1'b0);
        repeat (2) step('0, '1, 1'b0);

        // all channels requesting, no backpressure
        repeat (12) step('1, '1, 1'b1);
        repeat (4) step('0, '1, 1'b1);

        // channel 1 done token held back, then released
        repeat (15) step('1, 5'b11101, 1'b1);
        repeat (5) step('1, '1, 1'b1);
        repeat (4) step('0, '1, 1'b1);

        // two competing channels
        repeat (12) step(5'b01001, '1, 1'b1);
        repeat (4) step('0, '1, 1'b1);

        // randomized traffic
        repeat (400) step(N'($urandom), N'($urandom), ($urandom_range(0, 9) < 7));
        repeat (8) step('0, '1, 1'b1);

        // async reset with a held write and channels 1,3 busy
        step(5'b01010, '0, 1'b0);
        step(5'b01010, '0, 1'b1);
        step(5'b01010, '0, 1'b0);
        #2 reset = 1'b0;
        #1 chk_reset_outputs("midreset");
        step('1, '1, 1'b1);
        #1 chk_reset_outputs("inreset");
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (10) step('1, '1, 1'b1);
        repeat (4) step('0, '1, 1'b1);

        @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
